// File: rtl/mips_pkg.sv
// Shared widths and MEM-stage FSM encoding for the MIPS pipeline blocks.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads every cycle; a bubble forces all fields to zero.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              bubble,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [REG_W-1:0]  write_reg_in,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic [REG_W-1:0]  write_reg_w
);

  logic              reg_write_q,  reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] read_data_q,  read_data_d;
  logic [REG_W-1:0]  write_reg_q,  write_reg_d;

  // Select incoming fields or an all-zero bubble.
  always_comb begin
    reg_write_d  = reg_write_in;
    mem_to_reg_d = mem_to_reg_in;
    alu_result_d = alu_result_in;
    read_data_d  = read_data_in;
    write_reg_d  = write_reg_in;
    if (bubble) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_result_d = '0;
      read_data_d  = '0;
      write_reg_d  = '0;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign reg_write_w  = reg_write_q;
  assign mem_to_reg_w = mem_to_reg_q;
  assign alu_result_w = alu_result_q;
  assign read_data_w  = read_data_q;
  assign write_reg_w  = write_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: drives a variable-latency data memory, stalls the
// front of the pipeline while an access is outstanding, and fills MEM/WB.
//
// Memory handshake: DMemReq is a level that stays high from the first BUSY
// cycle until the cycle DMemAck is seen (or the timeout fires). Address,
// write data and write enable are registered and stable while DMemReq is
// high. DMemAck is only meaningful while DMemReq is high; an ack in IDLE is
// ignored. The access completes on the edge at which DMemReq && DMemAck.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              MemToRegM,
  input  logic              RegWriteM,
  input  logic [DATA_W-1:0] ALUresultM,
  input  logic [DATA_W-1:0] ReadData2M,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              StallM,
  output logic              DMemReq,
  output logic              DMemWe,
  output logic [DATA_W-1:0] DMemAddr,
  output logic [DATA_W-1:0] DMemWData,
  input  logic              DMemAck,
  input  logic [DATA_W-1:0] DMemRData,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [DATA_W-1:0] ALUresultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              MisalignErr,
  output logic              BusErr,
  output mem_state_e        DbgState
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              cap_rw_q, cap_rw_d;
  logic              cap_m2r_q, cap_m2r_d;
  logic [REG_W-1:0]  cap_wreg_q, cap_wreg_d;
  logic              misalign_q, misalign_d;
  logic              buserr_q, buserr_d;

  logic              access;
  logic              misaligned;
  logic              wb_bubble;
  logic              wb_rw;
  logic              wb_m2r;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_rdata;
  logic [REG_W-1:0]  wb_wreg;

  assign access     = MemReadM | MemWriteM;
  assign misaligned = (ALUresultM[1:0] != 2'b00);

  // Next-state, capture, stall and MEM/WB source selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    cap_rw_d   = cap_rw_q;
    cap_m2r_d  = cap_m2r_q;
    cap_wreg_d = cap_wreg_q;
    misalign_d = 1'b0;
    buserr_d   = buserr_q;
    StallM     = 1'b0;
    wb_bubble  = 1'b1;
    wb_rw      = RegWriteM;
    wb_m2r     = MemToRegM;
    wb_alu     = ALUresultM;
    wb_rdata   = '0;
    wb_wreg    = WriteRegM;

    case (state_q)
      IDLE: begin
        if (!access) begin
          wb_bubble = 1'b0;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          // A store wins when both read and write are flagged.
          StallM     = 1'b1;
          addr_d     = ALUresultM;
          wdata_d    = ReadData2M;
          we_d       = MemWriteM;
          cap_rw_d   = RegWriteM;
          cap_m2r_d  = MemToRegM;
          cap_wreg_d = WriteRegM;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (DMemAck) begin
          wb_bubble = 1'b0;
          wb_rw     = cap_rw_q;
          wb_m2r    = cap_m2r_q;
          wb_alu    = addr_q;
          wb_rdata  = we_q ? '0 : DMemRData;
          state_d   = IDLE;
        end else begin
          StallM = 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abandon the access; the instruction is dropped.
            buserr_d = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter, request capture and error flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cap_rw_q   <= 1'b0;
      cap_m2r_q  <= 1'b0;
      cap_wreg_q <= '0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      cap_rw_q   <= cap_rw_d;
      cap_m2r_q  <= cap_m2r_d;
      cap_wreg_q <= cap_wreg_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  assign DMemReq     = (state_q == BUSY);
  assign DMemWe      = we_q;
  assign DMemAddr    = addr_q;
  assign DMemWData   = wdata_q;
  assign MisalignErr = misalign_q;
  assign BusErr      = buserr_q;
  assign DbgState    = state_q;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .bubble        (wb_bubble),
    .reg_write_in  (wb_rw),
    .mem_to_reg_in (wb_m2r),
    .alu_result_in (wb_alu),
    .read_data_in  (wb_rdata),
    .write_reg_in  (wb_wreg),
    .reg_write_w   (RegWriteW),
    .mem_to_reg_w  (MemToRegW),
    .alu_result_w  (ALUresultW),
    .read_data_w   (ReadDataW),
    .write_reg_w   (WriteRegW)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model feeding two expected
// queues (per-cycle memory-side view and per-edge MEM/WB view).
module tb_mem_access_stage;
  import mips_pkg::*;

  localparam int T = 4;

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Rst_n;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        MemReadM, MemWriteM, MemToRegM, RegWriteM;
  logic [31:0] ALUresultM, ReadData2M;
  logic [4:0]  WriteRegM;
  logic        StallM, DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData;
  logic        DMemAck;
  logic [31:0] DMemRData;
  logic        RegWriteW, MemToRegW;
  logic [31:0] ALUresultW, ReadDataW;
  logic [4:0]  WriteRegW;
  logic        MisalignErr, BusErr;
  mem_state_e  DbgState;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(T)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
    .ALUresultM(ALUresultM), .ReadData2M(ReadData2M), .WriteRegM(WriteRegM),
    .StallM(StallM), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemAck(DMemAck), .DMemRData(DMemRData),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ALUresultW(ALUresultW), .ReadDataW(ReadDataW),
    .WriteRegW(WriteRegW), .MisalignErr(MisalignErr), .BusErr(BusErr), .DbgState(DbgState)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        mis;
    logic        berr;
  } wb_exp_t;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cyc_exp_t;

  wb_exp_t  wb_q[$];
  cyc_exp_t cyc_q[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  logic     berr_m  = 1'b0;
  logic     late_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  // MEM/WB and flag registers, sampled just after each rising edge.
  initial begin
    wb_exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (wb_q.size() != 0) begin
        e = wb_q.pop_front();
        check("RegWriteW",   64'(RegWriteW),   64'(e.rw));
        check("MemToRegW",   64'(MemToRegW),   64'(e.m2r));
        check("ALUresultW",  64'(ALUresultW),  64'(e.alu));
        check("ReadDataW",   64'(ReadDataW),   64'(e.rd));
        check("WriteRegW",   64'(WriteRegW),   64'(e.wr));
        check("MisalignErr", 64'(MisalignErr), 64'(e.mis));
        check("BusErr",      64'(BusErr),      64'(e.berr));
      end
    end
  end

  // Stall and memory-request side, sampled mid-cycle after inputs settle.
  initial begin
    cyc_exp_t c;
    forever begin
      @(negedge Clk);
      #2;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        check("StallM",  64'(StallM),  64'(c.stall));
        check("DMemReq", 64'(DMemReq), 64'(c.req));
        if (c.req) begin
          check("DMemAddr", 64'(DMemAddr), 64'(c.addr));
          check("DMemWe",   64'(DMemWe),   64'(c.we));
          if (c.we) check("DMemWData", 64'(DMemWData), 64'(c.wdata));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One instruction in EX/MEM. n = BUSY cycle on which memory acks (1..T),
  // 0 = memory never answers. Inputs are held while the access is pending.
  task automatic run_txn(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [4:0] wreg, input int n);
    cyc_exp_t c;
    wb_exp_t  b;
    logic     acc;
    int       busy;
    acc = rd | wr;
    @(negedge Clk);
    MemReadM = rd; MemWriteM = wr; MemToRegM = m2r; RegWriteM = rw;
    ALUresultM = alu; ReadData2M = wd; WriteRegM = wreg;
    DMemAck = late_ack | 1'($urandom_range(0, 1));
    DMemRData = $urandom;
    c = '0;
    b = '0;
    if (!acc) begin
      b.rw = rw; b.m2r = m2r; b.alu = alu; b.wr = wreg;
    end else if (alu[1:0] != 2'b00) begin
      b.mis = 1'b1;
    end else begin
      c.stall = 1'b1;
    end
    b.berr = berr_m;
    cyc_q.push_back(c);
    wb_q.push_back(b);
    if (acc && alu[1:0] == 2'b00) begin
      busy = (n == 0) ? T : n;
      for (int i = 1; i <= busy; i++) begin
        @(negedge Clk);
        DMemAck   = (i == n);
        DMemRData = (i == n) ? rdv : $urandom;
        c.stall = (i != n);
        c.req   = 1'b1;
        c.we    = wr;
        c.addr  = alu;
        c.wdata = wd;
        b = '0;
        if (i == n) begin
          b.rw = rw; b.m2r = m2r; b.alu = alu; b.wr = wreg;
          b.rd = wr ? 32'h0 : rdv;
        end else if (i == busy) begin
          berr_m = 1'b1;
        end
        b.berr = berr_m;
        cyc_q.push_back(c);
        wb_q.push_back(b);
      end
    end
  endtask

  task automatic run_random();
    int          kind;
    logic [31:0] alu;
    logic        rd, wr;
    int          n;
    kind = $urandom_range(0, 9);
    alu  = $urandom;
    n    = $urandom_range(1, T);
    rd   = 1'b0;
    wr   = 1'b0;
    if (kind >= 4) begin
      case ($urandom_range(0, 2))
        0: rd = 1'b1;
        1: wr = 1'b1;
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
    end
    if (kind == 4) begin
      if (alu[1:0] == 2'b00) alu[0] = 1'b1;
    end else if (kind >= 5) begin
      alu[1:0] = 2'b00;
    end
    if (kind == 9) n = 0;
    run_txn(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            alu, $urandom, $urandom, 5'($urandom_range(0, 31)), n);
  endtask

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; MemToRegM = 1'b0; RegWriteM = 1'b0;
    ALUresultM = '0; ReadData2M = '0; WriteRegM = '0;
    DMemAck = 1'b0; DMemRData = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".DMemReq"},     64'(DMemReq),     64'(0));
    check({tag, ".RegWriteW"},   64'(RegWriteW),   64'(0));
    check({tag, ".MemToRegW"},   64'(MemToRegW),   64'(0));
    check({tag, ".ALUresultW"},  64'(ALUresultW),  64'(0));
    check({tag, ".ReadDataW"},   64'(ReadDataW),   64'(0));
    check({tag, ".WriteRegW"},   64'(WriteRegW),   64'(0));
    check({tag, ".BusErr"},      64'(BusErr),      64'(0));
    check({tag, ".MisalignErr"}, 64'(MisalignErr), 64'(0));
    check({tag, ".state"},       64'(DbgState),    64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge Clk);
    #1;
    check_reset_outputs("por");
    check("por.StallM", 64'(StallM), 64'(0));
    Rst_n = 1'b1;

    // Directed cases.
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h0, 5'd5, 0);       // ALU op
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd8, 3); // load, 3 BUSY cycles
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h1234, 32'h0, 5'd0, 1);    // store, zero-wait
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 32'h0, 5'd3, 2);       // misaligned
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 32'h0, 5'd4, T);       // ack on last allowed cycle
    run_txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_0001, 32'h5555_AAAA, 5'd9, 2); // rd+wr = write
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 32'h0, 5'd6, 0);       // timeout
    late_ack = 1'b1;
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h0, 5'd7, 0);       // late ack ignored
    late_ack = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0048, 32'h0, 32'h0, 5'd2, 0);

    for (int k = 0; k < 300; k++) run_random();

    // Asynchronous reset in the middle of an access.
    repeat (2) @(negedge Clk);
    check("drain.wb_q",  64'(wb_q.size()),  64'(0));
    check("drain.cyc_q", 64'(cyc_q.size()), 64'(0));
    wb_q.delete();
    cyc_q.delete();
    MemReadM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1; MemToRegM = 1'b1;
    ALUresultM = 32'h0000_0500; WriteRegM = 5'd11; DMemAck = 1'b0;
    @(negedge Clk);
    check("midbusy.DMemReq", 64'(DMemReq), 64'(1));
    check("midbusy.state",   64'(DbgState), 64'(BUSY));
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("midbusy_rst");
    idle_inputs();
    repeat (2) @(negedge Clk);
    Rst_n  = 1'b1;
    berr_m = 1'b0;

    for (int k = 0; k < 60; k++) run_random();

    repeat (3) @(negedge Clk);
    check("end.wb_q",  64'(wb_q.size()),  64'(0));
    check("end.cyc_q", 64'(cyc_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
